logical_pipe: RTL
=================

// Module: logical_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle logical unit. Computes a bitwise
//  logic op on two WIDTH-bit operands and carries the result through a STAGES-deep
//  valid/ready pipeline with full backpressure. Sits between the operand-issue stage and
//  writeback in the multi-cycle datapath.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=1)
//  STAGES  2   pipeline register stages, 1..4; latency in cycles when not stalled
// PORTS
//  i_clk        in   1      clock, all state on rising edge
//  i_reset      in   1      synchronous, active-high reset
//  i_valid      in   1      upstream request valid
//  o_ready      out  1      block can accept a request this cycle
//  i_operand_a  in   WIDTH  operand A
//  i_operand_b  in   WIDTH  operand B
//  i_alu_op     in   3      operation select (see BEHAVIOUR)
//  i_tag        in   5      destination tag, carried unchanged alongside the result
//  o_valid      out  1      result valid
//  i_ready      in   1      downstream accepts the result
//  o_result     out  WIDTH  result
//  o_tag        out  5      tag belonging to o_result
// BEHAVIOUR
//  - Clocking/reset: one clock i_clk; reset i_reset is synchronous and active-high.
//  - Op map: 000 AND, 001 OR, 010 XOR, 011 ANDN (a & ~b), 100 ORN (a | ~b),
//    101 XNOR, 110 NOR, 111 reserved -> result all-zero.
//  - Result is computed combinationally at the input and captured in stage 0 on accept.
//  - Accept: a transfer happens when i_valid && o_ready. Emit: a transfer happens when
//    o_valid && i_ready.
//  - Stage k holds a valid bit plus result and tag. rdy_k = !valid_k || rdy_{k+1}, with
//    rdy_STAGES = i_ready. o_ready = rdy_0, combinational from i_ready (no skid buffer).
//  - When rdy_k is high, stage k loads from stage k-1, or from the input for k=0. A
//    stage that loads from an empty predecessor clears its valid bit. When rdy_k is low
//    the stage holds its contents.
//  - Latency: STAGES cycles from accept to o_valid when i_ready stays high.
//    Throughput: 1 op/cycle.
//  - Full: all stages valid and i_ready=0 -> o_ready=0. o_result/o_tag stay stable
//    while o_valid && !i_ready.
//  - Simultaneous accept and emit when full is legal: the pipe advances one slot with no
//    bubble.
//  - Reset, including mid-operation: every valid bit goes to 0; o_valid=0,
//    o_result='0, o_tag='0; in-flight ops are dropped. o_ready=1 in the first cycle
//    after reset.
//  - Data registers are also cleared on reset, so outputs never show X.
//  - Ordering: strictly in-order; no reordering and no duplication.
// CONFIGURATION
//  LOGICAL_PIPE_FLAGS_EN defined: adds outputs o_zero (1: o_result==0) and o_parity
//    (1: XOR-reduce of o_result). Both are computed at stage 0 and piped with the
//    result; both reset to 0.
//  Not defined: the ports are absent and no flag logic is built.
// STRUCTURE
//  - logical_pkg: typedef enum logic [2:0] logic_op_e {OP_AND..OP_NOR, OP_RSVD};
//    localparam TAG_W=5; function logic_eval(a,b,op), width-generic via a parameter.
//  - Sub-module logical_pipe_stage: one valid/data register slice with the rdy
//    chaining. It is instantiated STAGES times in a generate loop.
//  - Elaboration-time assertion: 1 <= STAGES <= 4.
// TESTING
//  1. Op sweep, STAGES=2, i_ready=1: a=F0F0_00FF, b=FF00_0F0F -> AND F000_000F,
//     OR FFF0_0FFF, XOR 0FF0_0FF0, ANDN 00F0_00F0, ORN F0FF_F0FF, XNOR F00F_F00F,
//     NOR 000F_F000, 111 -> 0; each result 2 cycles after its accept.
//  2. Backpressure: stream tags 1..6 and hold i_ready=0 for 5 cycles -> o_ready falls
//     after STAGES accepts, o_result holds stable. Release -> tags 1..6 emerge in order,
//     none lost or duplicated.
//  3. Full with simultaneous accept and emit: fill the pipe, then i_valid=i_ready=1 for
//     10 cycles -> one accept and one emit per cycle, no bubble.
//  4. Reset mid-stream: 3 ops in flight, pulse i_reset 1 cycle -> next cycle
//     o_valid=0, o_result=0, o_ready=1; the old tags never appear.
//  5. Parameter sweep: WIDTH=8/STAGES=1 and WIDTH=64/STAGES=4 with random ops vs a
//     scoreboard model -> bit-exact results, latency == STAGES.
//  6. LOGICAL_PIPE_FLAGS_EN: a=b=0x5 with XOR -> o_zero=1, o_parity=0; a=0x1,b=0 with
//     OR -> o_zero=0, o_parity=1.

Source files
------------

// File: rtl/logical_pkg.sv
// Shared types and the bitwise operation evaluator for the logical pipeline.
package logical_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_ANDN = 3'b011,
    OP_ORN  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOR  = 3'b110,
    OP_RSVD = 3'b111
  } logic_op_e;

  localparam int TAG_W       = 5;
  localparam int LOGIC_MAX_W = 128;

  // Operates at the widest supported width; callers zero-extend and truncate,
  // which is exact because every op is purely bitwise.
  function automatic logic [LOGIC_MAX_W-1:0] logic_eval(
    input logic [LOGIC_MAX_W-1:0] a,
    input logic [LOGIC_MAX_W-1:0] b,
    input logic_op_e              op
  );
    logic [LOGIC_MAX_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_ANDN: r = a & ~b;
      OP_ORN:  r = a | ~b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logical_pipe_stage.sv
// One valid/data register slice of the pipeline with ready chaining.
module logical_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // The slice may load whenever it is empty or its contents move on this cycle.
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

endmodule

// File: rtl/logical_pipe.sv
// Pipelined bitwise logic unit with valid/ready backpressure.
// Optional LOGICAL_PIPE_FLAGS_EN adds o_zero / o_parity result flags.
module logical_pipe
  import logical_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic [2:0]       i_alu_op,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [TAG_W-1:0] o_tag
`ifdef LOGICAL_PIPE_FLAGS_EN
  ,
  output logic             o_zero,
  output logic             o_parity
`endif
);

`ifdef LOGICAL_PIPE_FLAGS_EN
  localparam int FLAG_W = 2;
`else
  localparam int FLAG_W = 0;
`endif
  localparam int DW = WIDTH + TAG_W + FLAG_W;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("logical_pipe: STAGES must be within 1..4");
  end
  if (WIDTH < 1 || WIDTH > LOGIC_MAX_W) begin : g_bad_width
    $error("logical_pipe: WIDTH out of supported range");
  end

  logic [WIDTH-1:0] w_result;
  logic [DW-1:0]    w_in_data;

  assign w_result = WIDTH'(logic_eval(LOGIC_MAX_W'(i_operand_a),
                                      LOGIC_MAX_W'(i_operand_b),
                                      logic_op_e'(i_alu_op)));

`ifdef LOGICAL_PIPE_FLAGS_EN
  assign w_in_data = {^w_result, (w_result == '0), i_tag, w_result};
`else
  assign w_in_data = {i_tag, w_result};
`endif

  // Each slice owns its own wires so the ready chain never loops through one vector.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          w_up_valid;
    logic [DW-1:0] w_up_data;
    logic          w_down_ready;
    logic          w_valid;
    logic          w_rdy;
    logic [DW-1:0] w_data;

    if (k == 0) begin : g_first
      assign w_up_valid = i_valid;
      assign w_up_data  = w_in_data;
    end else begin : g_next
      assign w_up_valid = g_stage[k-1].w_valid;
      assign w_up_data  = g_stage[k-1].w_data;
    end

    if (k == STAGES - 1) begin : g_last
      assign w_down_ready = i_ready;
    end else begin : g_inner
      assign w_down_ready = g_stage[k+1].w_rdy;
    end

    logical_pipe_stage #(.DW(DW)) u_stage (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_valid (w_up_valid),
      .i_data  (w_up_data),
      .i_ready (w_down_ready),
      .o_ready (w_rdy),
      .o_valid (w_valid),
      .o_data  (w_data)
    );
  end

  assign o_ready  = g_stage[0].w_rdy;
  assign o_valid  = g_stage[STAGES-1].w_valid;
  assign o_result = g_stage[STAGES-1].w_data[WIDTH-1:0];
  assign o_tag    = g_stage[STAGES-1].w_data[WIDTH +: TAG_W];

`ifdef LOGICAL_PIPE_FLAGS_EN
  assign o_zero   = g_stage[STAGES-1].w_data[WIDTH+TAG_W];
  assign o_parity = g_stage[STAGES-1].w_data[WIDTH+TAG_W+1];
`endif

endmodule
